hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning event-counter width.
REQ-003 inclk  in  1  single clock; all state updates on rising edge.
REQ-004 inrst_n  in  1  reset, synchronous, active-low.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs, id_rt  in  REG_W each  ID source register addresses.
REQ-007 id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-008 id_dst  in  REG_W  ID destination register after regdst selection.
REQ-009 id_regwrite, id_memread  in  1 each  ID control bits.
REQ-010 ex_rs, ex_rt  in  REG_W each  source addresses held in the ID/EX buffer.
REQ-011 ex_branch_taken  in  1  EX branch resolved taken (branch AND zflag).
REQ-012 pc_we  out  1  PC write enable.
REQ-013 pc_sel  out  1  1 = PC loads branch target, 0 = PC+4.
REQ-014 ifid_we  out  1  IF/ID buffer write enable.
REQ-015 ifid_flush  out  1  IF/ID buffer loads NOP.
REQ-016 idex_bubble  out  1  ID/EX buffer loads zeroed control.
REQ-017 fwd_a, fwd_b  out  2 each  ALU operand source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 Scoreboard SHALL be three registered entries (EX, MEM, WB), each {valid, regwrite, memread, dst}, advancing every cycle: EX <= ID info (cleared when idex_bubble=1 or id_valid=0), MEM <= EX, WB <= MEM.
REQ-020 FSM states SHALL be WARM, RUN and FLUSH; WARM lasts exactly 2 cycles after reset release, then goes to RUN.
REQ-021 In WARM: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=1, and all inputs are ignored.
REQ-022 Load-use hazard (RUN only) SHALL be EX.valid & EX.memread & EX.dst!=0 & ((id_use_rs & id_rs==EX.dst) | (id_use_rt & id_rt==EX.dst)) & id_valid.
REQ-023 On load-use hazard: pc_we=0, ifid_we=0, idex_bubble=1 in the same cycle (combinational from registered state plus inputs); stall_cnt increments; FSM stays in RUN; the stall lasts exactly one cycle.
REQ-024 On ex_branch_taken in RUN: pc_sel=1, pc_we=1, ifid_flush=1, idex_bubble=1 in the same cycle; flush_cnt increments; next state is FLUSH.
REQ-025 A branch taken in the same cycle as a load-use hazard SHALL take priority: branch outputs apply and stall_cnt does not increment.
REQ-026 FLUSH SHALL last one cycle: load-use detection is disabled, ex_branch_taken is ignored, and pc_we=1, ifid_we=1, idex_bubble=1, ifid_flush=0; the state then returns to RUN.
REQ-027 Otherwise in RUN: pc_we=1, ifid_we=1, pc_sel=0, ifid_flush=0, idex_bubble=0.
REQ-028 fwd_a SHALL be 10 if MEM.valid & MEM.regwrite & MEM.dst!=0 & MEM.dst==ex_rs, else 01 if the same condition holds on WB, else 00; fwd_b is identical using ex_rt; MEM takes priority over WB.
REQ-029 Register 0 SHALL never cause a stall or a forward.
REQ-030 Counters SHALL saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-031 When inrst_n=0 at a clock edge: all scoreboard entries become invalid, FSM enters WARM with its cycle count at 0, and both counters become 0.
REQ-032 While inrst_n=0: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pc_sel=0, fwd_a=fwd_b=00.
REQ-033 Reset asserted mid-stall or mid-FLUSH SHALL abandon that operation with no residual stall or flush.

Structure
REQ-034 The FSM state encoding, forwarding select codes (FWD_RF, FWD_MEM, FWD_WB) and the scoreboard entry struct SHALL live in a shared package, pipe_pkg.
REQ-035 Forwarding comparison SHALL be one sub-module, fwd_unit, instantiated twice (operands A and B).

Verification
REQ-036 Reset released at cycle 0 -> pc_we=0 in cycles 0-1 and pc_we=1 in cycle 2 with no other input activity.
REQ-037 Load writing $8 in EX while ID reads rs=$8 -> exactly one cycle of pc_we=0/idex_bubble=1, stall_cnt=1; the next cycle fwd_a=01 once that ID instruction reaches EX.
REQ-038 ex_branch_taken=1 at cycle N -> pc_sel=1, ifid_flush=1 at N; state FLUSH at N+1 with no stall even if the ID inputs match a load; flush_cnt=1.
REQ-039 Writes to $5 in both MEM and WB while ex_rt=$5 -> fwd_b=10; with the MEM write removed -> fwd_b=01; with dst=$0 -> fwd_b=00.
REQ-040 Branch taken and load-use in the same cycle -> flush outputs apply, stall_cnt unchanged; stall_cnt forced to 0xFFFF and one more stall -> stays 0xFFFF.
REQ-041 inrst_n=0 during FLUSH -> the following cycle is WARM, both counters=0, and scoreboard empty (fwd_a=fwd_b=00).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM states, forwarding select codes
// and the scoreboard entry that tracks writers in EX, MEM and WB.
package pipe_pkg;

    // Scoreboard destinations are stored at this fixed width. Register
    // addresses of REG_W <= SB_DST_W bits are zero-extended into it.
    localparam int SB_DST_W = 8;

    typedef enum logic [1:0] {
        ST_WARM  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                memread;
        logic [SB_DST_W-1:0] dst;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // True when the entry will write register r. Register 0 is never a
    // real write target, so it never matches.
    function automatic logic sb_writes(input sb_entry_t e, input logic [SB_DST_W-1:0] r);
        return e.valid && e.regwrite && (e.dst != '0) && (e.dst == r);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU operand: the youngest in-flight writer of
// the operand's source register wins (MEM before WB), else the register file.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  sb_entry_t        mem_e,
    input  sb_entry_t        wb_e,
    input  logic [REG_W-1:0] src,
    output logic [1:0]       sel
);

    logic [SB_DST_W-1:0] src_ext;
    logic                unused_memread;

    assign src_ext        = SB_DST_W'(src);
    assign unused_memread = mem_e.memread ^ wb_e.memread;

    // Priority select: MEM result is newer than WB, so it is checked first.
    always_comb begin
        sel = FWD_RF;
        if (sb_writes(mem_e, src_ext)) begin
            sel = FWD_MEM;
        end else if (sb_writes(wb_e, src_ext)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, operand
// forwarding from a three-entry writer scoreboard, and saturating counters.
//
// Handshake-free block: every output is a per-cycle level. Stall means the
// PC and IF/ID hold (we=0) while ID/EX takes a bubble; flush means IF/ID
// loads a NOP and ID/EX takes a bubble while the PC moves on.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             inclk,
    input  logic             inrst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t    state;
    state_t    state_nx;
    logic      warm_cnt;
    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;
    logic      hit_rs;
    logic      hit_rt;
    logic      load_use;
    logic      br_take;
    logic      stall_inc;
    logic      flush_inc;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign dbg_state = state;

    // Load-use detection against the instruction currently in EX.
    always_comb begin
        hit_rs   = id_use_rs && (SB_DST_W'(id_rs) == sb_ex.dst);
        hit_rt   = id_use_rt && (SB_DST_W'(id_rt) == sb_ex.dst);
        load_use = (state == ST_RUN) && id_valid && sb_ex.valid && sb_ex.memread
                   && (sb_ex.dst != '0) && (hit_rs || hit_rt);
        br_take  = (state == ST_RUN) && ex_branch_taken;
    end

    // Next state and pipeline control; defaults are the held/reset values.
    always_comb begin
        state_nx    = state;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!inrst_n) begin
            state_nx = ST_WARM;
        end else begin
            case (state)
                ST_WARM: begin
                    if (warm_cnt) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (br_take) begin
                        // Branch wins over a simultaneous load-use stall.
                        pc_sel    = 1'b1;
                        pc_we     = 1'b1;
                        ifid_we   = 1'b1;
                        flush_inc = 1'b1;
                        state_nx  = ST_FLUSH;
                    end else if (load_use) begin
                        ifid_flush = 1'b0;
                        stall_inc  = 1'b1;
                    end else begin
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        ifid_flush  = 1'b0;
                        idex_bubble = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // The wrong-path instruction sitting in ID is dropped.
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b0;
                    state_nx   = ST_RUN;
                end
                default: state_nx = ST_WARM;
            endcase
        end
    end

    // FSM state register with the two-cycle warm-up counter.
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            state    <= ST_WARM;
            warm_cnt <= 1'b0;
        end else begin
            state    <= state_nx;
            warm_cnt <= (state == ST_WARM) && !warm_cnt;
        end
    end

    // Scoreboard shift: ID info enters EX unless bubbled, then ages to WB.
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            sb_ex  <= SB_EMPTY;
            sb_mem <= SB_EMPTY;
            sb_wb  <= SB_EMPTY;
        end else begin
            if (idex_bubble || !id_valid) begin
                sb_ex <= SB_EMPTY;
            end else begin
                sb_ex.valid    <= 1'b1;
                sb_ex.regwrite <= id_regwrite;
                sb_ex.memread  <= id_memread;
                sb_ex.dst      <= SB_DST_W'(id_dst);
            end
            sb_mem <= sb_ex;
            sb_wb  <= sb_mem;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .mem_e (sb_mem),
        .wb_e  (sb_wb),
        .src   (ex_rs),
        .sel   (fwd_a_raw)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .mem_e (sb_mem),
        .wb_e  (sb_wb),
        .src   (ex_rt),
        .sel   (fwd_b_raw)
    );

    // Forwarding is forced to the register file while reset is held.
    assign fwd_a = inrst_n ? fwd_a_raw : FWD_RF;
    assign fwd_b = inrst_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a cycle-level model of the pipeline
// rules checks every output each cycle; literal checks pin key scenarios.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic [4:0] id_rs, id_rt, id_dst, ex_rs, ex_rt;
    logic       ex_branch_taken;
    logic       pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    state_t     dbg_state;
    // Narrow-counter instance sharing the same inputs, for saturation.
    logic       n_pc_we, n_pc_sel, n_ifid_we, n_ifid_flush, n_idex_bubble;
    logic [1:0] n_fwd_a, n_fwd_b;
    logic [1:0] n_stall_cnt, n_flush_cnt;
    state_t     n_dbg_state;

    hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .inclk(clk), .inrst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .pc_we(pc_we), .pc_sel(pc_sel),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_n (
        .inclk(clk), .inrst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .pc_we(n_pc_we), .pc_sel(n_pc_sel),
        .ifid_we(n_ifid_we), .ifid_flush(n_ifid_flush), .idex_bubble(n_idex_bubble),
        .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt),
        .dbg_state(n_dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v;
        bit rw;
        bit mr;
        int dst;
    } m_ent_t;

    m_ent_t m_sb[3];        // [0]=EX, [1]=MEM, [2]=WB
    int     m_since_rel;    // cycles since reset was released
    bit     m_after_br;     // previous cycle took a branch in RUN
    int     m_stalls;       // unsaturated event totals
    int     m_flushes;
    bit     m_known = 1'b0;

    function automatic logic [1:0] m_fwd(input m_ent_t mem, input m_ent_t wb, input int src);
        if (mem.v && mem.rw && mem.dst != 0 && mem.dst == src) return 2'b10;
        if (wb.v && wb.rw && wb.dst != 0 && wb.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare process: outputs are checked mid-cycle, then the model takes
    // the clock edge that follows using the inputs held for that edge.
    always @(negedge clk) begin
        int  mode;  // 0 warm, 1 run, 2 flush
        bit  lu, br;
        bit  e_pc_we, e_pc_sel, e_ifid_we, e_ifid_flush, e_bubble, chk_ifid_we;
        m_ent_t nx;
        if (!rst_n) begin
            chk("rst_pc_we", 32'(pc_we), 32'd0);
            chk("rst_ifid_we", 32'(ifid_we), 32'd0);
            chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
            chk("rst_idex_bubble", 32'(idex_bubble), 32'd1);
            chk("rst_pc_sel", 32'(pc_sel), 32'd0);
            chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
            for (int i = 0; i < 3; i++) m_sb[i] = '{v: 1'b0, rw: 1'b0, mr: 1'b0, dst: 0};
            m_since_rel = 0;
            m_after_br  = 1'b0;
            m_stalls    = 0;
            m_flushes   = 0;
            m_known     = 1'b1;
        end else if (m_known) begin
            mode = (m_since_rel < 2) ? 0 : (m_after_br ? 2 : 1);
            br = (mode == 1) && ex_branch_taken;
            lu = (mode == 1) && id_valid && m_sb[0].v && m_sb[0].mr && m_sb[0].dst != 0 &&
                 ((id_use_rs && int'(id_rs) == m_sb[0].dst) || (id_use_rt && int'(id_rt) == m_sb[0].dst));
            chk_ifid_we = 1'b1;
            if (mode == 0) begin
                {e_pc_we, e_pc_sel, e_ifid_we, e_ifid_flush, e_bubble} = 5'b00011;
            end else if (mode == 2) begin
                {e_pc_we, e_pc_sel, e_ifid_we, e_ifid_flush, e_bubble} = 5'b10101;
            end else if (br) begin
                {e_pc_we, e_pc_sel, e_ifid_we, e_ifid_flush, e_bubble} = 5'b11011;
                chk_ifid_we = 1'b0;
            end else if (lu) begin
                {e_pc_we, e_pc_sel, e_ifid_we, e_ifid_flush, e_bubble} = 5'b00001;
            end else begin
                {e_pc_we, e_pc_sel, e_ifid_we, e_ifid_flush, e_bubble} = 5'b10100;
            end
            chk("pc_we", 32'(pc_we), 32'(e_pc_we));
            chk("pc_sel", 32'(pc_sel), 32'(e_pc_sel));
            if (chk_ifid_we) chk("ifid_we", 32'(ifid_we), 32'(e_ifid_we));
            chk("ifid_flush", 32'(ifid_flush), 32'(e_ifid_flush));
            chk("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
            chk("fwd_a", 32'(fwd_a), 32'(m_fwd(m_sb[1], m_sb[2], int'(ex_rs))));
            chk("fwd_b", 32'(fwd_b), 32'(m_fwd(m_sb[1], m_sb[2], int'(ex_rt))));
            chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls, 65535)));
            chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flushes, 65535)));
            chk("n_stall_cnt", 32'(n_stall_cnt), 32'(sat(m_stalls, 3)));
            chk("n_flush_cnt", 32'(n_flush_cnt), 32'(sat(m_flushes, 3)));
            // advance the model across the coming edge
            nx.v   = !e_bubble && id_valid;
            nx.rw  = nx.v && id_regwrite;
            nx.mr  = nx.v && id_memread;
            nx.dst = nx.v ? int'(id_dst) : 0;
            m_sb[2] = m_sb[1];
            m_sb[1] = m_sb[0];
            m_sb[0] = nx;
            if (lu && !br) m_stalls++;
            if (br) m_flushes++;
            m_after_br = br;
            if (m_since_rel < 100) m_since_rel++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] dst, input logic rw, input logic mr,
                          input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
        id_valid = v; id_dst = dst; id_regwrite = rw; id_memread = mr;
        id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    endtask

    task automatic id_nop();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        id_nop();
        ex_rs = 5'd0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("lit_rst_idex_bubble", 32'(idex_bubble), 32'd1);

        // warm-up: cycles 0 and 1 hold the PC, cycle 2 runs
        step(); rst_n = 1'b1;
        @(negedge clk); chk("lit_warm_c0", 32'(pc_we), 32'd0);
        step(); @(negedge clk); chk("lit_warm_c1", 32'(pc_we), 32'd0);
        step(); @(negedge clk); chk("lit_run_c2", 32'(pc_we), 32'd1);

        // load $8 in EX, ID reads rs=$8: one stall, then forward from WB
        step(); set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step(); set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        chk("lit_stall_pc_we", 32'(pc_we), 32'd0);
        chk("lit_stall_bubble", 32'(idex_bubble), 32'd1);
        step(); @(negedge clk);
        chk("lit_stall_once", 32'(pc_we), 32'd1);
        chk("lit_stall_cnt1", 32'(stall_cnt), 32'd1);
        step(); ex_rs = 5'd8; id_nop();
        @(negedge clk); chk("lit_fwd_a_wb", 32'(fwd_a), 32'b01);

        // branch taken together with a load-use hazard
        step(); ex_rs = 5'd0; set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step(); set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0); ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("lit_br_pc_sel", 32'(pc_sel), 32'd1);
        chk("lit_br_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("lit_br_pc_we", 32'(pc_we), 32'd1);
        step();   // FLUSH: branch input held high must be ignored
        @(negedge clk);
        chk("lit_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
        chk("lit_flush_pc_we", 32'(pc_we), 32'd1);
        chk("lit_flush_pc_sel", 32'(pc_sel), 32'd0);
        chk("lit_flush_cnt1", 32'(flush_cnt), 32'd1);
        chk("lit_br_stall_kept", 32'(stall_cnt), 32'd1);
        step(); ex_branch_taken = 1'b0; id_nop();
        @(negedge clk);
        chk("lit_flush_cnt_still1", 32'(flush_cnt), 32'd1);
        chk("lit_state_run", 32'(dbg_state), 32'(ST_RUN));

        // forwarding priority on operand B
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        step(); id_nop(); step(); ex_rt = 5'd5;
        @(negedge clk); chk("lit_fwd_b_mem", 32'(fwd_b), 32'b10);
        step(); @(negedge clk); chk("lit_fwd_b_wb", 32'(fwd_b), 32'b01);
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        step(); id_nop(); step(); ex_rt = 5'd0;
        @(negedge clk); chk("lit_fwd_b_r0", 32'(fwd_b), 32'b00);

        // repeated stalls: narrow counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            step(); set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            step(); set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
            step(); step(); id_nop();
            if (k == 3) begin
                @(negedge clk); chk("lit_n_sat3", 32'(n_stall_cnt), 32'd3);
            end
        end
        @(negedge clk);
        chk("lit_n_sat_hold", 32'(n_stall_cnt), 32'd3);
        chk("lit_stall_cnt6", 32'(stall_cnt), 32'd6);

        // reset asserted during FLUSH
        step(); ex_rs = 5'd8; ex_rt = 5'd8;
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(); step(); id_nop(); ex_branch_taken = 1'b1;
        step(); ex_branch_taken = 1'b0; rst_n = 1'b0;
        @(negedge clk); chk("lit_rst_in_flush_pc_we", 32'(pc_we), 32'd0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("lit_post_rst_state", 32'(dbg_state), 32'(ST_WARM));
        chk("lit_post_rst_stall", 32'(stall_cnt), 32'd0);
        chk("lit_post_rst_flush", 32'(flush_cnt), 32'd0);
        chk("lit_post_rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        step(); step();
        @(negedge clk); chk("lit_post_rst_run", 32'(pc_we), 32'd1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
